// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit MSB-first full-duplex words, all four CPOL/CPHA modes,
// one-hot active-low chip selects and a runtime half-period divider. Optional macro: SPI_LOOPBACK_EN.
module spi_master_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2,
    parameter int unsigned DIV_W  = 16,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div_factor,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              avail
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DIV_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]    r_half, w_half_nxt;
    logic [EDGE_W-1:0]   r_edge, w_edge_nxt;
    logic [DATA_W-1:0]   r_tx, w_tx_nxt;
    logic [DATA_W-1:0]   r_rx, w_rx_nxt;
    logic                r_cpol, w_cpol_nxt;
    logic                r_cpha, w_cpha_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_mosi, w_mosi_nxt;
    logic [NUM_CS-1:0]   r_cs_n, w_cs_n_nxt;
    logic [DATA_W-1:0]   r_data_out, w_data_out_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_avail, w_avail_nxt;

    logic [DIV_W-1:0]    w_h_eff;
    logic                w_cnt_done;
    logic [EDGE_W-1:0]   w_edge_inc;
    logic                w_leading;
    logic                w_last_edge;
    logic                w_sample_bit;

    // Active-low one-hot select; an out-of-range index leaves every line high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (CS_W'(i) == sel) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign w_h_eff     = (div_factor == '0) ? DIV_W'(1) : div_factor;
    assign w_cnt_done  = (r_cnt == (r_half - DIV_W'(1)));
    assign w_edge_inc  = r_edge + EDGE_W'(1);
    assign w_leading   = ~r_edge[0];
    assign w_last_edge = (w_edge_inc == EDGE_W'(2 * DATA_W));

`ifdef SPI_LOOPBACK_EN
    logic r_lb, w_lb_nxt;
    assign w_sample_bit = r_lb ? r_mosi : miso;
`else
    assign w_sample_bit = miso;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_half     <= DIV_W'(1);
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_avail    <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            r_lb       <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_half     <= w_half_nxt;
            r_edge     <= w_edge_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_cpol     <= w_cpol_nxt;
            r_cpha     <= w_cpha_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_data_out <= w_data_out_nxt;
            r_busy     <= w_busy_nxt;
            r_avail    <= w_avail_nxt;
`ifdef SPI_LOOPBACK_EN
            r_lb       <= w_lb_nxt;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_half_nxt     = r_half;
        w_edge_nxt     = r_edge;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_cpol_nxt     = r_cpol;
        w_cpha_nxt     = r_cpha;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        w_data_out_nxt = r_data_out;
        w_busy_nxt     = r_busy;
        w_avail_nxt    = 1'b0;
`ifdef SPI_LOOPBACK_EN
        w_lb_nxt       = r_lb;
`endif

        unique case (r_state)
            S_IDLE: begin
                w_sclk_nxt = cpol;
                w_cnt_nxt  = '0;
                w_edge_nxt = '0;
                if (start) begin
                    w_state_nxt = S_SETUP;
                    w_cpol_nxt  = cpol;
                    w_cpha_nxt  = cpha;
                    w_half_nxt  = w_h_eff;
                    w_busy_nxt  = 1'b1;
                    w_cs_n_nxt  = cs_decode(cs_sel);
                    w_rx_nxt    = '0;
`ifdef SPI_LOOPBACK_EN
                    w_lb_nxt    = loopback;
`endif
                    // CPHA=0 needs the MSB on the line before the first edge
                    if (!cpha) begin
                        w_mosi_nxt = data_in[DATA_W-1];
                        w_tx_nxt   = {data_in[DATA_W-2:0], 1'b0};
                    end else begin
                        w_tx_nxt   = data_in;
                    end
                end
            end

            S_SETUP: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_XFER;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_W'(1);
                end
            end

            S_XFER: begin
                if (w_cnt_done) begin
                    w_cnt_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    w_edge_nxt = w_edge_inc;
                    if (w_leading == r_cpha) begin
                        // drive edge: CPHA=1 leading, CPHA=0 trailing except the final one
                        if (r_cpha || !w_last_edge) begin
                            w_mosi_nxt = r_tx[DATA_W-1];
                            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        w_rx_nxt = {r_rx[DATA_W-2:0], w_sample_bit};
                    end
                    if (w_last_edge) w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end

            S_HOLD: begin
                w_sclk_nxt = r_cpol;
                if (w_cnt_done) begin
                    w_cnt_nxt      = '0;
                    w_cs_n_nxt     = '1;
                    w_busy_nxt     = 1'b0;
                    w_data_out_nxt = r_rx;
                    w_avail_nxt    = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mosi     = r_mosi;
    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign avail    = r_avail;

endmodule
